mpsoc_msi_wb_burst_master: RTL and testbench

//  Synthesizable Wishbone B3 master that turns one command (addr, beat count, dir, BTE) into a

---
 rtl/mpsoc_msi_wb_burst_master_if.sv | 26 ++
 rtl/mpsoc_msi_wb_burst_master.sv | 136 +++++++++++++
 tb/tb_mpsoc_msi_wb_burst_master.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_msi_wb_burst_master_if.sv
// mpsoc_msi_wb_burst_master_if: Wishbone B3 bus between the burst master and its slave
interface mpsoc_msi_wb_burst_master_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_we_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;
    logic            wb_rty_i;
    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/mpsoc_msi_wb_burst_master.sv
// mpsoc_msi_wb_burst_master: Wishbone B3 classic/incrementing-burst master; define WB_BURST_MASTER_RTY_EN for rty retries
module mpsoc_msi_wb_burst_master #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int LW      = 8,
    parameter int RTY_MAX = 4
) (
    input  logic            wb_clk,
    input  logic            wb_rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [LW-1:0]   cmd_len,
    input  logic [1:0]      cmd_bte,
    input  logic [DW-1:0]   wdat,
    input  logic [DW/8-1:0] wsel,
    input  logic            wdat_valid,
    output logic            wdat_ready,
    output logic [DW-1:0]   rdat,
    output logic            rdat_valid,
    output logic            rdat_last,
    output logic            done,
    output logic            done_err,
    mpsoc_msi_wb_burst_master_if.master wb
);
    localparam int SW = DW / 8;
    localparam int OB = $clog2(SW);
    localparam int RW = $clog2(RTY_MAX + 1);
`ifdef WB_BURST_MASTER_RTY_EN
    localparam logic [RW-1:0] RTY_LIM = RW'(RTY_MAX);
`else
    localparam logic [RW-1:0] RTY_LIM = '0;
`endif
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state;
    logic [LW-1:0] rem;
    logic [LW:0]   load_rem;
    logic          single;
    logic          rty_wait;
    logic [RW-1:0] rty_cnt;
    logic          good, fail, retry, load;
    logic [AW-1:0] wrap_m, nxt_adr;

    assign cmd_ready  = state == IDLE;
    assign done       = state == DONE;
    assign good       = wb.wb_stb_o & wb.wb_ack_i & !wb.wb_err_i & !wb.wb_rty_i;
    assign retry      = wb.wb_stb_o & wb.wb_rty_i & !wb.wb_err_i & (rty_cnt != RTY_LIM);
    assign fail       = wb.wb_stb_o & (wb.wb_err_i | (wb.wb_rty_i & (rty_cnt == RTY_LIM)));
    assign wdat_ready = (state == BURST) & wb.wb_we_o & (|load_rem) & !rty_wait & (!wb.wb_stb_o | good);
    assign load       = wdat_ready & wdat_valid;
    assign wrap_m     = wb.wb_bte_o == 2'b01 ? AW'(3 << OB) :
                        wb.wb_bte_o == 2'b10 ? AW'(7 << OB) :
                        wb.wb_bte_o == 2'b11 ? AW'(15 << OB) : '1;
    assign nxt_adr    = (wb.wb_adr_o & ~wrap_m) | ((wb.wb_adr_o + AW'(SW)) & wrap_m);

    // command FSM, registered Wishbone outputs and read return path
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= IDLE;
            single      <= 1'b0;
            rem         <= '0;
            load_rem    <= '0;
            done_err    <= 1'b0;
            rdat        <= '0;
            rdat_valid  <= 1'b0;
            rdat_last   <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_cti_o <= 3'b000;
            wb.wb_bte_o <= 2'b00;
        end else begin
            rdat_valid <= (state == BURST) && good && !wb.wb_we_o;
            rdat_last  <= (state == BURST) && good && !wb.wb_we_o && rem == '0;
            if ((state == BURST) && good && !wb.wb_we_o)
                rdat <= wb.wb_dat_i;
            if (state == IDLE && cmd_valid) begin
                state       <= BURST;
                single      <= cmd_len == '0;
                rem         <= cmd_len;
                load_rem    <= cmd_we ? {1'b0, cmd_len} + (LW+1)'(1) : '0;
                done_err    <= 1'b0;
                wb.wb_cyc_o <= 1'b1;
                wb.wb_stb_o <= !cmd_we;
                wb.wb_we_o  <= cmd_we;
                wb.wb_adr_o <= cmd_adr;
                wb.wb_sel_o <= cmd_we ? '0 : '1;
                wb.wb_dat_o <= '0;
                wb.wb_cti_o <= (cmd_we || cmd_len == '0) ? 3'b000 : 3'b010;
                wb.wb_bte_o <= cmd_len == '0 ? 2'b00 : cmd_bte;
            end else if (state == BURST) begin
                if (fail || (good && rem == '0)) begin
                    state       <= DONE;
                    done_err    <= fail;
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                end else begin
                    wb.wb_stb_o <= rty_wait || (!retry && (!wb.wb_we_o || load || (wb.wb_stb_o && !good)));
                    if (good) begin
                        rem         <= rem - LW'(1);
                        wb.wb_adr_o <= nxt_adr;
                    end
                    if (good && !wb.wb_we_o)
                        wb.wb_cti_o <= rem == LW'(1) ? 3'b111 : 3'b010;
                    if (load) begin
                        wb.wb_dat_o <= wdat;
                        wb.wb_sel_o <= wsel;
                        load_rem    <= load_rem - (LW+1)'(1);
                        wb.wb_cti_o <= single ? 3'b000 : load_rem == (LW+1)'(1) ? 3'b111 : 3'b010;
                    end
                end
            end else if (state == DONE) begin
                state    <= IDLE;
                done_err <= 1'b0;
            end
        end
    end

    // retry bookkeeping: one stb-low cycle after rty, consecutive rty count per beat
    always_ff @(posedge wb_clk) begin
        if (wb_rst || state != BURST) begin
            rty_wait <= 1'b0;
            rty_cnt  <= '0;
        end else begin
            rty_wait <= retry;
            rty_cnt  <= good ? '0 : retry ? rty_cnt + RW'(1) : rty_cnt;
        end
    end
endmodule

// File: tb/tb_mpsoc_msi_wb_burst_master.sv
// tb_mpsoc_msi_wb_burst_master: directed bench for the Wishbone burst master (RTY_MAX=2)
module tb_mpsoc_msi_wb_burst_master;
    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [7:0]  cmd_len = '0;
    logic [1:0]  cmd_bte = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  wsel = '0;
    logic        wdat_valid = 1'b0;
    logic        cmd_ready, wdat_ready, rdat_valid, rdat_last, done, done_err;
    logic [31:0] rdat;

    int n_chk = 0;
    int n_err = 0;
    int resp [32];
    int sc = 0;
    logic noise = 1'b0;
    int wd_mode = 0;
    logic [31:0] wd_tab [8] = '{32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333,
                                32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777};
    logic [3:0]  sel_tab [8] = '{4'hF, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    logic [31:0] rd4_adr [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [2:0]  rd4_cti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
    logic [31:0] wr8_adr [8] = '{32'h1C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h10, 32'h14, 32'h18};

    logic [31:0] adr_q[$], dat_q[$], rd_q[$];
    logic [2:0]  cti_q[$];
    logic [1:0]  bte_q[$];
    logic [3:0]  sel_q[$];
    int rv_cnt = 0, rl_cnt = 0, rl_idx = 0, dn_cnt = 0, hs_cnt = 0, gaps = 0, cyc_fall = 0;
    int st300 = 0, cyc_n = 0, t_beat = 0, t_done = 0;
    logic de = 1'b0, cyc_after_err = 1'b1, err_prev = 1'b0, cyc_prev = 1'b0;
    logic bgood;

    mpsoc_msi_wb_burst_master_if #(.DW(32), .AW(32)) bus();

    mpsoc_msi_wb_burst_master #(.DW(32), .AW(32), .LW(8), .RTY_MAX(2)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
        .cmd_len(cmd_len), .cmd_bte(cmd_bte),
        .wdat(wdat), .wsel(wsel), .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
        .rdat(rdat), .rdat_valid(rdat_valid), .rdat_last(rdat_last),
        .done(done), .done_err(done_err), .wb(bus)
    );

    always #5 wb_clk = ~wb_clk;

    // scripted slave: per stb-cycle response 0 ack, 1 err, 2 rty, 3 wait, 4 ack+err
    always_comb begin
        bus.wb_ack_i = bus.wb_stb_o & (resp[sc % 32] == 0 || resp[sc % 32] == 4);
        bus.wb_err_i = (bus.wb_stb_o & (resp[sc % 32] == 1 || resp[sc % 32] == 4)) | (noise & !bus.wb_stb_o);
        bus.wb_rty_i = (bus.wb_stb_o & resp[sc % 32] == 2) | (noise & !bus.wb_stb_o);
        bus.wb_dat_i = 32'hA000_0000 | bus.wb_adr_o;
    end

    assign bgood = bus.wb_stb_o & bus.wb_ack_i & !bus.wb_err_i & !bus.wb_rty_i;

    always @(posedge wb_clk)
        if (cmd_valid & cmd_ready) sc <= 0;
        else if (bus.wb_stb_o) sc <= sc + 1;

    always @(negedge wb_clk) begin
        cyc_n++;
        if (bgood) begin
            adr_q.push_back(bus.wb_adr_o);
            cti_q.push_back(bus.wb_cti_o);
            bte_q.push_back(bus.wb_bte_o);
            dat_q.push_back(bus.wb_dat_o);
            sel_q.push_back(bus.wb_sel_o);
            t_beat = cyc_n;
        end
        if (bus.wb_stb_o && bus.wb_adr_o == 32'h300) st300++;
        if (rdat_valid) begin
            rv_cnt++;
            rd_q.push_back(rdat);
            if (rdat_last) begin
                rl_cnt++;
                rl_idx = rv_cnt;
            end
        end
        if (done) begin
            dn_cnt++;
            de = done_err;
            t_done = cyc_n;
        end
        if (wdat_valid & wdat_ready) hs_cnt++;
        if (bus.wb_cyc_o & !bus.wb_stb_o) gaps++;
        if (cyc_prev & !bus.wb_cyc_o) cyc_fall++;
        if (err_prev) cyc_after_err = bus.wb_cyc_o;
        err_prev = bus.wb_stb_o & bus.wb_err_i;
        cyc_prev = bus.wb_cyc_o;
    end

    initial forever begin
        @(posedge wb_clk);
        #1;
        wdat_valid = wd_mode == 1 || (wd_mode == 2 && !wdat_valid);
        wdat = wd_tab[hs_cnt % 8];
        wsel = sel_tab[hs_cnt % 8];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_cmd(input logic we, input logic [31:0] adr, input logic [7:0] len, input logic [1:0] bte);
        adr_q.delete(); cti_q.delete(); bte_q.delete(); dat_q.delete(); sel_q.delete(); rd_q.delete();
        rv_cnt = 0; rl_cnt = 0; rl_idx = 0; dn_cnt = 0; hs_cnt = 0; gaps = 0; cyc_fall = 0;
        st300 = 0; cyc_after_err = 1'b1; de = 1'b0;
        check("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_bte = bte;
        @(posedge wb_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 300 && dn_cnt == 0; i++) @(posedge wb_clk);
        repeat (3) @(posedge wb_clk);
        #1;
        check({tag, "_done_cnt"}, dn_cnt, 1);
    endtask

    task automatic set_resp(input int a, input int b, input int c, input int rest);
        resp[0] = a; resp[1] = b; resp[2] = c;
        for (int i = 3; i < 32; i++) resp[i] = rest;
    endtask

    initial begin
        set_resp(0, 0, 0, 0);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b0;
        @(negedge wb_clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_cyc", bus.wb_cyc_o, 0);
        check("rst_stb", bus.wb_stb_o, 0);
        check("rst_adr", bus.wb_adr_o, 0);
        check("rst_cti", bus.wb_cti_o, 0);
        check("rst_wdat_ready", wdat_ready, 0);
        check("rst_rdat_valid", rdat_valid, 0);
        check("rst_done", done, 0);
        @(posedge wb_clk);
        #1;

        start_cmd(1'b0, 32'h100, 8'd3, 2'b00);
        wait_done("rd4");
        check("rd4_beats", adr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rd4_adr%0d", i), adr_q[i], rd4_adr[i]);
            check($sformatf("rd4_cti%0d", i), cti_q[i], rd4_cti[i]);
            check($sformatf("rd4_bte%0d", i), bte_q[i], 0);
            check($sformatf("rd4_sel%0d", i), sel_q[i], 4'hF);
            check($sformatf("rd4_rdat%0d", i), rd_q[i], 32'hA000_0000 | rd4_adr[i]);
        end
        check("rd4_rvalid", rv_cnt, 4);
        check("rd4_rlast_cnt", rl_cnt, 1);
        check("rd4_rlast_idx", rl_idx, 4);
        check("rd4_done_lat", t_done - t_beat, 1);
        check("rd4_done_err", de, 0);

        wd_mode = 1;
        start_cmd(1'b1, 32'h200, 8'd0, 2'b01);
        wait_done("wr1");
        wd_mode = 0;
        check("wr1_beats", adr_q.size(), 1);
        check("wr1_adr", adr_q[0], 32'h200);
        check("wr1_cti", cti_q[0], 0);
        check("wr1_bte", bte_q[0], 0);
        check("wr1_dat", dat_q[0], 32'hDEADBEEF);
        check("wr1_sel", sel_q[0], 4'hF);
        check("wr1_hs", hs_cnt, 1);
        check("wr1_done_err", de, 0);

        wd_mode = 2;
        noise = 1'b1;
        start_cmd(1'b1, 32'h1C, 8'd7, 2'b01);
        wait_done("wr8");
        wd_mode = 0;
        noise = 1'b0;
        check("wr8_beats", adr_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("wr8_adr%0d", i), adr_q[i], wr8_adr[i]);
            check($sformatf("wr8_cti%0d", i), cti_q[i], i == 7 ? 3'b111 : 3'b010);
            check($sformatf("wr8_bte%0d", i), bte_q[i], 2'b01);
            check($sformatf("wr8_dat%0d", i), dat_q[i], wd_tab[i]);
            check($sformatf("wr8_sel%0d", i), sel_q[i], sel_tab[i]);
        end
        check("wr8_hs", hs_cnt, 8);
        check("wr8_gaps", gaps > 2, 1);
        check("wr8_cyc_fall", cyc_fall, 1);
        check("wr8_done_err", de, 0);

        set_resp(0, 0, 1, 0);
        start_cmd(1'b0, 32'h400, 8'd5, 2'b00);
        wait_done("rderr");
        check("rderr_rvalid", rv_cnt, 2);
        check("rderr_cyc_after", cyc_after_err, 0);
        check("rderr_done_err", de, 1);
        check("rderr_cmd_ready", cmd_ready, 1);

        set_resp(4, 0, 0, 0);
        start_cmd(1'b0, 32'h500, 8'd1, 2'b00);
        wait_done("ackerr");
        check("ackerr_rvalid", rv_cnt, 0);
        check("ackerr_beats", adr_q.size(), 0);
        check("ackerr_done_err", de, 1);

        set_resp(0, 3, 3, 3);
        start_cmd(1'b0, 32'h80, 8'd3, 2'b00);
        repeat (3) @(posedge wb_clk);
        #1 wb_rst = 1'b1;
        @(posedge wb_clk);
        #1 wb_rst = 1'b0;
        @(negedge wb_clk);
        check("mrst_cyc", bus.wb_cyc_o, 0);
        check("mrst_stb", bus.wb_stb_o, 0);
        check("mrst_cmd_ready", cmd_ready, 1);
        check("mrst_beats", adr_q.size(), 1);
        repeat (3) @(negedge wb_clk);
        check("mrst_no_done", dn_cnt, 0);
        set_resp(0, 0, 0, 0);
        @(posedge wb_clk);
        #1;
        start_cmd(1'b0, 32'h5C, 8'd1, 2'b10);
        wait_done("wrap8");
        check("wrap8_adr0", adr_q[0], 32'h5C);
        check("wrap8_adr1", adr_q[1], 32'h40);
        check("wrap8_cti0", cti_q[0], 3'b010);
        check("wrap8_cti1", cti_q[1], 3'b111);
        check("wrap8_bte", bte_q[1], 2'b10);
        check("wrap8_rvalid", rv_cnt, 2);
        check("wrap8_done_err", de, 0);

`ifdef WB_BURST_MASTER_RTY_EN
        set_resp(2, 2, 0, 0);
        start_cmd(1'b0, 32'h300, 8'd1, 2'b00);
        wait_done("rty2");
        check("rty2_stb_at_adr", st300, 3);
        check("rty2_adr0", adr_q[0], 32'h300);
        check("rty2_adr1", adr_q[1], 32'h304);
        check("rty2_rvalid", rv_cnt, 2);
        check("rty2_done_err", de, 0);
        set_resp(2, 2, 2, 0);
        start_cmd(1'b0, 32'h340, 8'd0, 2'b00);
        wait_done("rty3");
        check("rty3_rvalid", rv_cnt, 0);
        check("rty3_done_err", de, 1);
`else
        set_resp(2, 0, 0, 0);
        start_cmd(1'b0, 32'h300, 8'd1, 2'b00);
        wait_done("rty1");
        check("rty1_rvalid", rv_cnt, 0);
        check("rty1_done_err", de, 1);
`endif
        set_resp(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
